lfsr_word_deser: RTL and testbench
==================================

# lfsr_word_deser

Serial-to-parallel stage placed directly downstream of the 4-bit LFSR generator. It consumes the generator's serial bit stream (one bit per `valid` pulse, LSB first) and assembles it into WIDTH-bit words. Completed words are presented through a one-entry output buffer with a valid/ready handshake, so the parallel consumer may stall without losing the word in progress. Words that complete while the buffer is still full are dropped and flagged.

## Interface
Parameters:
- WIDTH, 4: bits per assembled word; matches the generator register width.
- CNT_W, 8: width of the delivered-word counter.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- serial_in  in  1  serial data bit; sampled only when serial_valid=1.
- serial_valid  in  1  qualifies serial_in; one bit is accepted per high cycle.
- word_ready  in  1  consumer can accept word_out this cycle.
- clear_overflow  in  1  one-cycle pulse that clears the overflow flag.
- word_out  out  WIDTH  assembled word; bit 0 is the first bit received.
- word_valid  out  1  word_out holds an undelivered word.
- overflow  out  1  sticky; a completed word was dropped because the buffer was full.
- word_count  out  CNT_W  number of words handed over (valid&&ready), wraps modulo 2^CNT_W.

## Operation
- Collector: shift register sr[WIDTH-1:0] plus bit counter bit_cnt (0..WIDTH-1). On serial_valid: sr <= {serial_in, sr[WIDTH-1:1]}, bit_cnt++. The WIDTH-th accepted bit completes a word; the completed value is {serial_in, sr[WIDTH-1:1]}, and bit_cnt returns to 0.
- Output buffer: two states, EMPTY (word_valid=0) and FULL (word_valid=1).
  - EMPTY + completion -> load word_out, go to FULL.
  - FULL + word_ready, no completion -> EMPTY; word_count++.
  - FULL + word_ready + completion in the same cycle -> load the new word, stay FULL, word_count++, no overflow.
  - FULL + !word_ready + completion -> keep the held word unchanged, drop the new word, set overflow; the collector still restarts at bit_cnt=0.
- word_out is stable whenever word_valid=1 && word_ready=0.
- overflow: set by a drop, cleared by clear_overflow. If a drop and clear_overflow occur in the same cycle, set wins.
- word_count increments only on a handshake and wraps from 2^CNT_W-1 to 0.
- serial_valid=0 cycles leave the collector untouched. There is no timeout, so gaps between bits are allowed.
- Reset (including mid-word): sr=0, bit_cnt=0, partial bits are discarded, state=EMPTY.

## Timing
- Reset values: word_out=0, word_valid=0, overflow=0, word_count=0.
- Latency: word_valid rises on the clock edge that samples the WIDTH-th serial_valid bit, i.e. it is visible one cycle after that bit is presented.
- Handshake completes on the rising edge where word_valid && word_ready. Back-to-back completions are sustainable when word_ready is held high.
- overflow rises on the same edge as the dropped completion. clear_overflow takes effect on the next edge.
- Reset has priority over every other input.

## Structure
- Shared package lfsr_pkg holds:
  - LFSR_WIDTH=4, used as the WIDTH default.
  - WORD_CNT_W=8.
  - enum buf_state_t {BUF_EMPTY, BUF_FULL}.
- Sub-module bit_collector contains the shift register and bit counter. It outputs word_done (1-cycle, combinational on serial_valid at bit WIDTH-1) and word_data.
- The top level holds the buffer FSM, the overflow flag and word_count.

## Test plan
- Reset, then serial bits 1,0,1,1 on consecutive cycles with word_ready=1 -> word_out=4'hD and word_valid high for 1 cycle; word_count=1.
- Same bits with gaps of 3 idle cycles between them -> identical result 4'hD; no spurious word_valid.
- word_ready=0; send 4'hD then 4'h3 -> word_out stays 4'hD; overflow=1 at the 8th bit; word_count=0. Then word_ready=1 -> 4'hD delivered. Then clear_overflow -> overflow=0.
- Word held with word_ready=0; raise word_ready on the exact cycle the next word (4'hA) completes -> 4'hA loaded, word_valid stays 1, overflow stays 0, word_count+1.
- Two bits sent, then reset pulse, then 0,0,0,1 -> word_out=4'h8; the earlier partial bits are absent.
- Deliver 256 words with word_ready=1 -> word_count wraps to 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator and its downstream word deserializer.
// Holds the default widths and the output-buffer state encoding.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 4;
  localparam int WORD_CNT_W = 8;

  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/lfsr_word_deser_bit_collector.sv
// Shift-register collector: gathers WIDTH serial bits (LSB first) and pulses
// word_done, combinationally, on the cycle that presents the final bit.
module bit_collector import lfsr_pkg::*; #(
  parameter int WIDTH = LFSR_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic             word_done,
  output logic [WIDTH-1:0] word_data
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_r;
  logic [BC_W-1:0]  bit_cnt_r;
  logic [WIDTH-1:0] sr_next_s;
  logic [BC_W-1:0]  bit_cnt_next_s;
  logic             last_bit_s;

  assign last_bit_s = (bit_cnt_r == LAST_BIT);
  assign word_done  = serial_valid && last_bit_s;
  // The completed word includes the bit being presented this cycle.
  assign word_data  = {serial_in, sr_r[WIDTH-1:1]};

  // Next collector state: shift on each accepted bit, restart count after the last.
  always_comb begin
    sr_next_s      = sr_r;
    bit_cnt_next_s = bit_cnt_r;
    if (serial_valid) begin
      sr_next_s = {serial_in, sr_r[WIDTH-1:1]};
      if (last_bit_s) begin
        bit_cnt_next_s = {BC_W{1'b0}};
      end else begin
        bit_cnt_next_s = bit_cnt_r + BC_W'(1);
      end
    end else begin
      sr_next_s      = sr_r;
      bit_cnt_next_s = bit_cnt_r;
    end
  end

  // Collector registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr_r      <= {WIDTH{1'b0}};
      bit_cnt_r <= {BC_W{1'b0}};
    end else begin
      sr_r      <= sr_next_s;
      bit_cnt_r <= bit_cnt_next_s;
    end
  end

endmodule

// File: rtl/lfsr_word_deser.sv
// Serial-to-parallel stage behind the LFSR generator: one-entry output buffer
// with valid/ready handshake, sticky drop flag and a delivered-word counter.
module lfsr_word_deser import lfsr_pkg::*; #(
  parameter int WIDTH = LFSR_WIDTH,
  parameter int CNT_W = WORD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             word_ready,
  input  logic             clear_overflow,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] word_count
);

  logic             word_done_s;
  logic [WIDTH-1:0] word_data_s;

  buf_state_t       state_r;
  buf_state_t       state_next_s;
  logic [WIDTH-1:0] word_out_r;
  logic [WIDTH-1:0] word_next_s;
  logic             word_valid_r;
  logic             overflow_r;
  logic             overflow_next_s;
  logic [CNT_W-1:0] word_count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             drop_s;

  bit_collector #(
    .WIDTH (WIDTH)
  ) u_collector (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .word_done    (word_done_s),
    .word_data    (word_data_s)
  );

  // Buffer FSM next state; a same-cycle handshake frees the slot for the new word.
  always_comb begin
    state_next_s    = state_r;
    word_next_s     = word_out_r;
    count_next_s    = word_count_r;
    drop_s          = 1'b0;
    overflow_next_s = overflow_r;
    case (state_r)
      BUF_EMPTY: begin
        if (word_done_s) begin
          word_next_s  = word_data_s;
          state_next_s = BUF_FULL;
        end else begin
          state_next_s = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (word_ready) begin
          count_next_s = word_count_r + CNT_W'(1);
          if (word_done_s) begin
            word_next_s  = word_data_s;
            state_next_s = BUF_FULL;
          end else begin
            state_next_s = BUF_EMPTY;
          end
        end else begin
          if (word_done_s) begin
            drop_s = 1'b1;
          end else begin
            drop_s = 1'b0;
          end
          state_next_s = BUF_FULL;
        end
      end
      default: begin
        state_next_s = BUF_EMPTY;
      end
    endcase
    // A drop in the same cycle as a clear request must leave the flag set.
    if (drop_s) begin
      overflow_next_s = 1'b1;
    end else if (clear_overflow) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
  end

  // Buffer, flag and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= BUF_EMPTY;
      word_out_r   <= {WIDTH{1'b0}};
      word_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      word_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_next_s;
      word_out_r   <= word_next_s;
      word_valid_r <= (state_next_s == BUF_FULL);
      overflow_r   <= overflow_next_s;
      word_count_r <= count_next_s;
    end
  end

  assign word_out   = word_out_r;
  assign word_valid = word_valid_r;
  assign overflow   = overflow_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_lfsr_word_deser.sv
// Directed self-checking bench for lfsr_word_deser (WIDTH=4, CNT_W=8).
module tb_lfsr_word_deser;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b0;
  logic       serial_valid = 1'b0;
  logic       word_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [3:0] word_out;
  logic       word_valid;
  logic       overflow;
  logic [7:0] word_count;

  int n_vec = 0;
  int n_err = 0;

  lfsr_word_deser #(
    .WIDTH (4),
    .CNT_W (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .serial_in      (serial_in),
    .serial_valid   (serial_valid),
    .word_ready     (word_ready),
    .clear_overflow (clear_overflow),
    .word_out       (word_out),
    .word_valid     (word_valid),
    .overflow       (overflow),
    .word_count     (word_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one bit for one cycle; serial_valid drops afterwards.
  task automatic send_bit(input logic b);
    serial_in    = b;
    serial_valid = 1'b1;
    tick();
    serial_valid = 1'b0;
  endtask

  // Four consecutive bits, LSB first, with serial_valid held high throughout.
  task automatic send_word(input logic [3:0] w);
    for (int k = 0; k < 4; k++) begin
      serial_in    = w[k];
      serial_valid = 1'b1;
      tick();
    end
    serial_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_word_out", word_out, 4'h0);
    check("rst_valid", word_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_count", word_count, 8'd0);

    // Consecutive bits 1,0,1,1 -> 4'hD
    word_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t1_no_early_valid", word_valid, 1'b0);
    send_bit(1'b1);
    check("t1_valid", word_valid, 1'b1);
    check("t1_word", word_out, 4'hD);
    tick();
    check("t1_valid_one_cycle", word_valid, 1'b0);
    check("t1_count", word_count, 8'd1);

    // Same bits separated by 3 idle cycles
    send_bit(1'b1);
    for (int g = 0; g < 3; g++) tick();
    check("t2_gap_a", word_valid, 1'b0);
    send_bit(1'b0);
    for (int g = 0; g < 3; g++) tick();
    check("t2_gap_b", word_valid, 1'b0);
    send_bit(1'b1);
    for (int g = 0; g < 3; g++) tick();
    check("t2_gap_c", word_valid, 1'b0);
    send_bit(1'b1);
    check("t2_valid", word_valid, 1'b1);
    check("t2_word", word_out, 4'hD);
    tick();
    check("t2_count", word_count, 8'd2);

    // Stalled consumer: second word dropped, overflow raised
    word_ready = 1'b0;
    send_word(4'hD);
    check("t3_held_valid", word_valid, 1'b1);
    check("t3_no_ovf_yet", overflow, 1'b0);
    send_word(4'h3);
    check("t3_word_kept", word_out, 4'hD);
    check("t3_overflow", overflow, 1'b1);
    check("t3_count", word_count, 8'd2);
    word_ready = 1'b1;
    tick();
    check("t3_delivered", word_valid, 1'b0);
    check("t3_count_after", word_count, 8'd3);
    check("t3_ovf_sticky", overflow, 1'b1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t3_ovf_cleared", overflow, 1'b0);

    // Ready rises on the exact cycle the next word 4'hA completes
    word_ready = 1'b0;
    send_word(4'hD);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("t4_still_d", word_out, 4'hD);
    word_ready = 1'b1;
    send_bit(1'b1);
    check("t4_word_a", word_out, 4'hA);
    check("t4_valid", word_valid, 1'b1);
    check("t4_no_ovf", overflow, 1'b0);
    check("t4_count", word_count, 8'd4);
    tick();
    check("t4_drained", word_valid, 1'b0);
    check("t4_count2", word_count, 8'd5);

    // Reset mid-word discards partial bits
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_count", word_count, 8'd0);
    check("t5_rst_valid", word_valid, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    check("t5_no_early_valid", word_valid, 1'b0);
    send_bit(1'b1);
    check("t5_valid", word_valid, 1'b1);
    check("t5_word", word_out, 4'h8);
    tick();
    check("t5_count", word_count, 8'd1);

    // 255 further back-to-back words wrap the counter to 0
    for (int i = 0; i < 255; i++) begin
      logic [3:0] w;
      w = 4'(i);
      send_word(w);
      check("t6_word", word_out, w);
    end
    tick();
    check("t6_wrap_count", word_count, 8'd0);
    check("t6_valid_low", word_valid, 1'b0);

    // Drop and clear in the same cycle: set wins
    word_ready = 1'b0;
    send_word(4'h5);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    clear_overflow = 1'b1;
    send_bit(1'b0);
    check("t7_set_wins", overflow, 1'b1);
    check("t7_word_kept", word_out, 4'h5);
    tick();
    clear_overflow = 1'b0;
    check("t7_cleared", overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
